uart_ocp_bridge: RTL and testbench

//  UART-to-OCP master bridge: host frames on RXD become single OCP read/write requests; results return on TXD.

---
 rtl/uart_ocp_bridge.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_ocp_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ocp_bridge.sv
// UART-to-OCP master bridge: 'W'/'R' host frames become single OCP requests; ACK, read data or NAK return on TXD.
// Optional inter-byte timeout for partial frames is enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_ocp_bridge #(
  parameter int unsigned BAUD_DIV     = 434,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RXD,
  output logic              TXD,
  output logic [2:0]        uart_MCmd,
  output logic [ADDR_W-1:0] uart_MAddr,
  output logic [DATA_W-1:0] uart_MData,
  input  logic              uart_SCmdAccept,
  input  logic [DATA_W-1:0] uart_SData,
  input  logic [1:0]        uart_SResp,
  output logic              uart_active_n
);
  localparam int unsigned ADDR_B = ADDR_W / 8;
  localparam int unsigned DATA_B = DATA_W / 8;
  localparam int unsigned CW     = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2 - 1);
  localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT_BITS * BAUD_DIV - 1);

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_SEND = 3'd5;

  // ---------------- RX ----------------
  logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic          rx_busy_q, rx_valid_q, rx_stop_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_stop_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rxd_meta_q <= RXD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_valid_q <= 1'b0;
      rx_stop_q  <= 1'b0;
      if (!rx_busy_q) begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= HALF_BIT;
          rx_bit_q  <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end else begin
        rx_cnt_q <= FULL_BIT;
        if (rx_bit_q == 4'd0) begin
          // start bit no longer low at its centre: treat as a glitch
          if (rxd_sync_q) rx_busy_q <= 1'b0;
          else            rx_bit_q  <= 4'd1;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q  <= 1'b0;
          rx_stop_q  <= 1'b1;
          rx_valid_q <= rxd_sync_q;
        end else begin
          rx_sh_q  <= {rxd_sync_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 4'd1;
        end
      end
    end
  end

  // ---------------- TX ----------------
  logic          tx_load;
  logic [7:0]    tx_byte;
  logic          txd_q, tx_busy_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_sh_q;
  logic          tx_end;

  assign tx_end = tx_busy_q && (tx_cnt_q == '0) && (tx_bit_q == 4'd9);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txd_q     <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
    end else if (tx_load) begin
      txd_q     <= 1'b0;
      tx_busy_q <= 1'b1;
      tx_cnt_q  <= FULL_BIT;
      tx_bit_q  <= '0;
      tx_sh_q   <= {1'b1, tx_byte};
    end else if (tx_busy_q) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_q <= tx_cnt_q - 1'b1;
      end else if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
        txd_q     <= 1'b1;
      end else begin
        txd_q    <= tx_sh_q[0];
        tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
        tx_bit_q <= tx_bit_q + 4'd1;
        tx_cnt_q <= FULL_BIT;
      end
    end
  end

  // ---------------- frame FSM ----------------
  logic [2:0]        state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic              act_n_q, act_n_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        rep_n_q, rep_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [DATA_W-1:0] data_q, data_d, mdata_q, mdata_d, rep_q, rep_d;
  logic [2:0]        mcmd_q, mcmd_d;
  logic [31:0]       to_cnt_q;
  logic              timeout_hit, enter_req, in_get;

  assign in_get = (state_q == S_ADDR) || (state_q == S_DATA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     to_cnt_q <= '0;
    else if (rx_stop_q || !in_get)    to_cnt_q <= '0;
    else if (to_cnt_q != TO_LAST)     to_cnt_q <= to_cnt_q + 32'd1;
  end

`ifdef UART_BRIDGE_TIMEOUT_EN
  assign timeout_hit = in_get && (to_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    act_n_d   = act_n_q;
    cnt_d     = cnt_q;
    rep_n_d   = rep_n_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rep_d     = rep_q;
    mcmd_d    = mcmd_q;
    maddr_d   = maddr_q;
    mdata_d   = mdata_q;
    tx_load   = 1'b0;
    tx_byte   = '0;
    enter_req = 1'b0;
    case (state_q)
      S_IDLE: if (rx_valid_q) begin
        act_n_d = 1'b0;
        cnt_d   = '0;
        if (rx_sh_q == 8'h57 || rx_sh_q == 8'h52) begin
          op_wr_d = (rx_sh_q == 8'h57);
          state_d = S_ADDR;
        end else begin
          tx_load = 1'b1;
          tx_byte = 8'h15;
          rep_n_d = '0;
          state_d = S_SEND;
        end
      end
      S_ADDR: if (rx_valid_q) begin
        addr_d = ADDR_W'({addr_q, rx_sh_q});
        if (cnt_q == 8'(ADDR_B - 1)) begin
          cnt_d = '0;
          if (op_wr_q) state_d = S_DATA;
          else         enter_req = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DATA: if (rx_valid_q) begin
        data_d = DATA_W'({data_q, rx_sh_q});
        if (cnt_q == 8'(DATA_B - 1)) begin
          cnt_d     = '0;
          enter_req = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_REQ: if (uart_SCmdAccept) begin
        mcmd_d = CMD_IDLE;
        if (op_wr_q) begin
          tx_load = 1'b1;
          tx_byte = 8'h06;
          rep_n_d = '0;
          state_d = S_SEND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (uart_SResp == 2'b01) begin
          tx_load = 1'b1;
          tx_byte = uart_SData[DATA_W-1 -: 8];
          rep_d   = uart_SData << 8;
          rep_n_d = 8'(DATA_B - 1);
          state_d = S_SEND;
        end else if (uart_SResp != 2'b00) begin
          tx_load = 1'b1;
          tx_byte = 8'h15;
          rep_n_d = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: if (tx_end) begin
        if (rep_n_q != '0) begin
          tx_load = 1'b1;
          tx_byte = rep_q[DATA_W-1 -: 8];
          rep_d   = rep_q << 8;
          rep_n_d = rep_n_q - 8'd1;
        end else begin
          act_n_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit && !rx_valid_q) begin
      state_d = S_IDLE;
      act_n_d = 1'b1;
      cnt_d   = '0;
    end
    // bus outputs are registered on REQ entry so they appear in REQ's first cycle
    if (enter_req) begin
      state_d = S_REQ;
      mcmd_d  = op_wr_q ? CMD_WR : CMD_RD;
      maddr_d = addr_d;
      mdata_d = op_wr_q ? data_d : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      act_n_q <= 1'b1;
      cnt_q   <= '0;
      rep_n_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rep_q   <= '0;
      mcmd_q  <= CMD_IDLE;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      act_n_q <= act_n_d;
      cnt_q   <= cnt_d;
      rep_n_q <= rep_n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rep_q   <= rep_d;
      mcmd_q  <= mcmd_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  assign TXD           = txd_q;
  assign uart_MCmd     = mcmd_q;
  assign uart_MAddr    = maddr_q;
  assign uart_MData    = mdata_q;
  assign uart_active_n = act_n_q;
endmodule

// File: tb/tb_uart_ocp_bridge.sv
// Directed self-checking bench for uart_ocp_bridge with BAUD_DIV=16, 16-bit address and data.
`timescale 1ns/1ps
module tb_uart_ocp_bridge;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RXD;
  logic        TXD;
  logic [2:0]  uart_MCmd;
  logic [15:0] uart_MAddr, uart_MData, uart_SData;
  logic        uart_SCmdAccept;
  logic [1:0]  uart_SResp;
  logic        uart_active_n;

  int checks = 0, failures = 0;
  int cmd_cycles = 0, tx_starts = 0, rd = 0;
  logic [2:0]  last_cmd = '0;
  logic [15:0] last_addr = '0, last_data = '0;
  logic [7:0]  txq[$];
  int          acc_dly = 0, resp_dly = 0;
  logic [1:0]  resp_code = 2'b00;
  logic [15:0] sdata = '0;

  uart_ocp_bridge #(.BAUD_DIV(BD), .ADDR_W(16), .DATA_W(16), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .reset_n(reset_n), .RXD(RXD), .TXD(TXD),
    .uart_MCmd(uart_MCmd), .uart_MAddr(uart_MAddr), .uart_MData(uart_MData),
    .uart_SCmdAccept(uart_SCmdAccept), .uart_SData(uart_SData), .uart_SResp(uart_SResp),
    .uart_active_n(uart_active_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RXD = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (BD) @(negedge clk);
    end
    RXD = stop_bit;
    repeat (BD) @(negedge clk);
    RXD = 1'b1;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int t = 0;
    while ((txq.size() - rd) < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_count"}, txq.size() - rd, n);
  endtask

  // TXD receiver model: samples each bit at its centre
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset_n && TXD === 1'b0) begin
        tx_starts++;
        repeat (BD/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = TXD;
        end
        repeat (BD) @(negedge clk);
        txq.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    if (uart_MCmd != 3'b000) begin
      cmd_cycles++;
      last_cmd  = uart_MCmd;
      last_addr = uart_MAddr;
      last_data = uart_MData;
    end
  end

  // OCP slave: accept after acc_dly cycles, read response resp_dly cycles later
  initial begin
    logic is_rd;
    uart_SCmdAccept = 1'b0;
    uart_SResp      = 2'b00;
    uart_SData      = '0;
    forever begin
      @(negedge clk);
      if (reset_n && uart_MCmd != 3'b000) begin
        is_rd = (uart_MCmd == 3'b010);
        repeat (acc_dly) @(negedge clk);
        uart_SCmdAccept = 1'b1;
        @(negedge clk);
        uart_SCmdAccept = 1'b0;
        if (is_rd) begin
          repeat (resp_dly) @(negedge clk);
          uart_SResp = resp_code;
          uart_SData = sdata;
          @(negedge clk);
          uart_SResp = 2'b00;
          uart_SData = '0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s0, t;
    reset_n = 1'b0;
    RXD     = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_txd",    TXD, 1);
    check("rst_mcmd",   uart_MCmd, 0);
    check("rst_maddr",  uart_MAddr, 0);
    check("rst_mdata",  uart_MData, 0);
    check("rst_active", uart_active_n, 1);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: write with immediate accept
    c0 = cmd_cycles;
    send_byte(8'h57, 1'b1);
    check("t1_active_low", uart_active_n, 0);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    wait_tx(1, "t1_ack");
    check("t1_ack", txq[rd], 8'h06); rd += 1;
    check("t1_cmd_cycles", cmd_cycles - c0, 1);
    check("t1_cmd",  last_cmd, 3'b001);
    check("t1_addr", last_addr, 16'h1234);
    check("t1_data", last_data, 16'hABCD);
    repeat (20) @(negedge clk);
    check("t1_active_high", uart_active_n, 1);

    // 2: read with delayed accept and DVA
    acc_dly = 5; resp_dly = 3; resp_code = 2'b01; sdata = 16'hBEEF;
    c0 = cmd_cycles;
    send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    wait_tx(2, "t2_rdata");
    check("t2_byte0", txq[rd], 8'hBE);
    check("t2_byte1", txq[rd+1], 8'hEF); rd += 2;
    check("t2_cmd_cycles", cmd_cycles - c0, 6);
    check("t2_cmd",  last_cmd, 3'b010);
    check("t2_addr", last_addr, 16'h0010);
    check("t2_data", last_data, 16'h0000);
    repeat (20) @(negedge clk);

    // 3: read answered with ERR
    acc_dly = 0; resp_code = 2'b11;
    c0 = cmd_cycles;
    send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1);
    wait_tx(1, "t3_nak");
    check("t3_nak", txq[rd], 8'h15); rd += 1;
    check("t3_active_in_stop", uart_active_n, 0);
    check("t3_addr", last_addr, 16'h0020);
    check("t3_cmd_cycles", cmd_cycles - c0, 1);
    repeat (BD) @(negedge clk);
    check("t3_active_high", uart_active_n, 1);

    // 4: unknown opcode, framing error, start glitch
    send_byte(8'h41, 1'b1);
    wait_tx(1, "t4_nak");
    check("t4_nak", txq[rd], 8'h15); rd += 1;
    repeat (30) @(negedge clk);
    c0 = cmd_cycles; s0 = tx_starts;
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    RXD = 1'b0;
    repeat (4) @(negedge clk);
    RXD = 1'b1;
    repeat (300) @(negedge clk);
    check("t4_no_tx",  tx_starts - s0, 0);
    check("t4_no_cmd", cmd_cycles - c0, 0);
    check("t4_active", uart_active_n, 1);

    // 5a: reset while replying
    s0 = tx_starts;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h06, 1'b1);
    t = 0;
    while (tx_starts == s0 && t < 3000) begin @(negedge clk); t++; end
    check("t5_tx_started", tx_starts - s0, 1);
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5s_txd",    TXD, 1);
    check("t5s_mcmd",   uart_MCmd, 0);
    check("t5s_active", uart_active_n, 1);
    s0 = tx_starts;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (250) @(negedge clk);
    check("t5s_no_partial", tx_starts - s0, 0);
    rd = txq.size();

    // 5b: reset while the request is pending
    acc_dly = 60;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h07, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h08, 1'b1);
    t = 0;
    while (uart_MCmd == 3'b000 && t < 500) begin @(negedge clk); t++; end
    check("t5r_req_active", uart_MCmd, 3'b001);
    reset_n = 1'b0;
    #1;
    check("t5r_mcmd",   uart_MCmd, 0);
    check("t5r_maddr",  uart_MAddr, 0);
    check("t5r_active", uart_active_n, 1);
    check("t5r_txd",    TXD, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    acc_dly = 0;
    rd = txq.size();
    c0 = cmd_cycles;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    wait_tx(1, "t5_after");
    check("t5_after_ack", txq[rd], 8'h06); rd += 1;
    check("t5_after_addr", last_addr, 16'h0001);
    check("t5_after_data", last_data, 16'h0002);
    check("t5_after_cmd_cycles", cmd_cycles - c0, 1);
    repeat (30) @(negedge clk);

    // 6: stalled partial frame
    c0 = cmd_cycles;
    send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1);
    repeat (21*BD) @(negedge clk);
    check("t6_no_cmd", cmd_cycles - c0, 0);
`ifdef UART_BRIDGE_TIMEOUT_EN
    check("t6_timeout_active", uart_active_n, 1);
`else
    check("t6_still_active", uart_active_n, 0);
    send_byte(8'h34, 1'b1); send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    wait_tx(1, "t6_ack");
    check("t6_ack", txq[rd], 8'h06); rd += 1;
    check("t6_addr", last_addr, 16'h1234);
    check("t6_data", last_data, 16'hABCD);
    check("t6_cmd_cycles", cmd_cycles - c0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
